// File: rtl/systolic_output_collector.sv
// -----------------------------------------------------------------------------
// systolic_output_collector
//
// Collects the partial sums leaving the bottom of a systolic array, where the
// columns arrive on a diagonal (column c lags column 0 by c cycles). The block
// de-skews the columns back into a single row and saturates every element to
// FIXED_POINT_WIDTH. Each finished row is queued in a small FIFO that drains
// through a valid/ready handshake.
//
// The array is never stalled. If a finished row arrives while the FIFO is full
// and nothing is popped on that edge, the row is dropped and a sticky overflow
// flag is raised.
//
// Timing: valid_in sampled at edge E0 -> row written into the FIFO at edge
// E0+NUM_COLUMNS -> row_valid_out high in the following cycle (FIFO empty).
//
// Ports
//   clk_in              single clock
//   reset_in            synchronous active-high reset, highest priority
//   clear_in            synchronous flush, same effect as reset_in
//   valid_in            column 0 partial sum valid this cycle
//   partial_sum_in      NUM_COLUMNS signed sums, column 0 in the LSBs
//   row_ready_in        downstream accepts the head row
//   row_valid_out       FIFO head row is valid
//   row_data_out        saturated, aligned head row, column 0 in the LSBs
//   row_saturated_out   at least one element of the head row was clamped
//   occupancy_out       number of rows held in the FIFO
//   overflow_error_out  sticky, a row was dropped because the FIFO was full
//   rows_collected_out  rows written into the FIFO (wraps at 16 bits)
//
// Assumes PARTIAL_SUM_WIDTH >= FIXED_POINT_WIDTH and FIFO_DEPTH a power of
// two, at least 2.
// -----------------------------------------------------------------------------
module systolic_output_collector #(
  parameter int NUM_COLUMNS       = 4,
  parameter int FIXED_POINT_WIDTH = 16,
  parameter int PARTIAL_SUM_WIDTH = 20,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                      clk_in,
  input  logic                                      reset_in,
  input  logic                                      clear_in,
  input  logic                                      valid_in,
  input  logic [NUM_COLUMNS*PARTIAL_SUM_WIDTH-1:0]  partial_sum_in,
  input  logic                                      row_ready_in,
  output logic                                      row_valid_out,
  output logic [NUM_COLUMNS*FIXED_POINT_WIDTH-1:0]  row_data_out,
  output logic                                      row_saturated_out,
  output logic [$clog2(FIFO_DEPTH):0]               occupancy_out,
  output logic                                      overflow_error_out,
  output logic [15:0]                               rows_collected_out
);

  localparam int FW    = FIXED_POINT_WIDTH;
  localparam int PSW   = PARTIAL_SUM_WIDTH;
  localparam int RW    = NUM_COLUMNS * FW;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // Representable range of one output element, expressed at the
  // partial-sum width so that the comparisons stay signed and exact.
  localparam logic signed [PSW-1:0] SAT_MAX = {{(PSW-FW+1){1'b0}}, {(FW-1){1'b1}}};
  localparam logic signed [PSW-1:0] SAT_MIN = {{(PSW-FW+1){1'b1}}, {(FW-1){1'b0}}};
  localparam logic [FW-1:0]         OUT_MAX = {1'b0, {(FW-1){1'b1}}};
  localparam logic [FW-1:0]         OUT_MIN = {1'b1, {(FW-1){1'b0}}};

  // reset_in and clear_in have the same effect on every register.
  logic flush;
  assign flush = reset_in | clear_in;

  // ---------------------------------------------------------------------------
  // De-skew: column c waits NUM_COLUMNS-1-c cycles. All columns of one row
  // are then present together in the cycle before edge E0+NUM_COLUMNS-1.
  // ---------------------------------------------------------------------------
  logic [NUM_COLUMNS-1:0][PSW-1:0] aligned;
  logic                            aligned_valid;

  for (genvar c = 0; c < NUM_COLUMNS; c++) begin : g_skew
    localparam int STAGES = NUM_COLUMNS - 1 - c;
    if (STAGES > 0) begin : g_pipe
      logic [PSW-1:0] pipe [STAGES];

      // NOTE: sequential state is updated with non-blocking assignments so
      // every stage samples the value its neighbour held before the edge.
      always_ff @(posedge clk_in) begin
        if (flush) begin
          for (int s = 0; s < STAGES; s++) pipe[s] <= '0;
        end else begin
          pipe[0] <= partial_sum_in[c*PSW +: PSW];
          for (int s = 1; s < STAGES; s++) pipe[s] <= pipe[s-1];
        end
      end

      assign aligned[c] = pipe[STAGES-1];
    end else begin : g_direct
      // The last column arrives last; it needs no delay.
      assign aligned[c] = partial_sum_in[c*PSW +: PSW];
    end
  end

  // valid_in travels with column 0, through the same number of stages.
  if (NUM_COLUMNS > 1) begin : g_valid_pipe
    logic [NUM_COLUMNS-2:0] valid_pipe;

    always_ff @(posedge clk_in) begin
      if (flush) begin
        valid_pipe <= '0;
      end else begin
        valid_pipe <= {valid_pipe[NUM_COLUMNS-2:0], valid_in} >> 0;
      end
    end

    assign aligned_valid = valid_pipe[NUM_COLUMNS-2];
  end else begin : g_valid_direct
    assign aligned_valid = valid_in;
  end

  // ---------------------------------------------------------------------------
  // Saturation: clamp each aligned element to FW bits and remember whether
  // any element of the row was clamped.
  // ---------------------------------------------------------------------------
  logic [RW-1:0]          clamp_data;
  logic [NUM_COLUMNS-1:0] clamp_flag;

  // NOTE: every output of this block gets a default before any branch, so
  // no path can leave a value unassigned and infer a latch.
  always_comb begin
    clamp_data = '0;
    clamp_flag = '0;
    for (int c = 0; c < NUM_COLUMNS; c++) begin
      if ($signed(aligned[c]) > SAT_MAX) begin
        clamp_data[c*FW +: FW] = OUT_MAX;
        clamp_flag[c]          = 1'b1;
      end else if ($signed(aligned[c]) < SAT_MIN) begin
        clamp_data[c*FW +: FW] = OUT_MIN;
        clamp_flag[c]          = 1'b1;
      end else begin
        clamp_data[c*FW +: FW] = aligned[c][FW-1:0];
      end
    end
  end

  logic          sat_valid;
  logic [RW-1:0] sat_data;
  logic          sat_flag;

  always_ff @(posedge clk_in) begin
    if (flush) begin
      sat_valid <= 1'b0;
      sat_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      sat_valid <= aligned_valid;
      sat_data  <= clamp_data;
      sat_flag  <= |clamp_flag;
    end
  end

  // ---------------------------------------------------------------------------
  // Row FIFO
  // ---------------------------------------------------------------------------
  logic [RW-1:0]    data_mem [FIFO_DEPTH];
  logic             flag_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic [15:0]      rows_collected;
  logic             overflow;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign empty = (count == '0);
  assign full  = (count == OCC_W'(FIFO_DEPTH));
  assign pop   = !empty && row_ready_in;
  // A full FIFO still takes the new row when the head leaves on the same edge.
  assign push  = sat_valid && (!full || pop);
  assign drop  = sat_valid && full && !pop;

  // NOTE: the storage array has no reset; the pointers and count define what
  // is valid, and the outputs are forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push) begin
      data_mem[wr_ptr] <= sat_data;
      flag_mem[wr_ptr] <= sat_flag;
    end
  end

  always_ff @(posedge clk_in) begin
    if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rows_collected <= '0;
      overflow       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + PTR_W'(1);
        rows_collected <= rows_collected + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The head entry is not written while it is presented (a write to
  // a full FIFO only lands in the head slot on the edge that pops it), so
  // the data stays stable while the row waits for row_ready_in.
  // ---------------------------------------------------------------------------
  assign row_valid_out      = !empty;
  assign row_data_out       = empty ? '0 : data_mem[rd_ptr];
  assign row_saturated_out  = empty ? 1'b0 : flag_mem[rd_ptr];
  assign occupancy_out      = count;
  assign overflow_error_out = overflow;
  assign rows_collected_out = rows_collected;

endmodule
